// File: rtl/cv32e40p_core_v_xif_pkg.sv
// CORE-V-XIF interface types shared by the core and the reference coprocessor,
// plus the op encoding and buffer entry layout used by the responder.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_NUM_RS    = 3;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [1:0]                            mode;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
    logic [X_NUM_RS-1:0]                   rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  localparam logic [2:0] F3_ADD3 = 3'b000;
  localparam logic [2:0] F3_MAXU = 3'b001;
  localparam logic [2:0] F3_POPC = 3'b010;

  typedef enum logic [1:0] {
    OP_ADD3 = 2'd0,
    OP_MAXU = 2'd1,
    OP_POPC = 2'd2
  } xif_op_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [4:0]             rd;
    xif_op_e                op;
    logic [X_RFR_WIDTH-1:0] opa;
    logic [X_RFR_WIDTH-1:0] opb;
    logic [X_RFR_WIDTH-1:0] opc;
  } xif_entry_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cv32e40p_xif_coproc_responder_chk.sv
// Protocol invariants of the XIF responder: unique in-flight ids, stable
// result while stalled, and no second commit for the same instruction.
module cv32e40p_xif_coproc_responder_chk
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                             clk,
  input logic                             rst_n,
  input logic [DEPTH-1:0]                 ent_valid,
  input logic [DEPTH-1:0]                 ent_committed,
  input logic [DEPTH-1:0][X_ID_WIDTH-1:0] ent_id,
  input logic                             commit_valid,
  input logic [X_ID_WIDTH-1:0]            commit_id,
  input logic                             result_valid,
  input logic                             result_ready,
  input x_result_t                        result
);

  logic dup_id_s;
  logic recommit_s;

  // Pairwise id comparison across live entries and commit lookup
  always_comb begin
    dup_id_s   = 1'b0;
    recommit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      recommit_s = recommit_s | (commit_valid && ent_valid[i] && ent_committed[i] &&
                                 (ent_id[i] == commit_id));
      for (int j = i + 1; j < DEPTH; j++) begin
        dup_id_s = dup_id_s | (ent_valid[i] && ent_valid[j] && (ent_id[i] == ent_id[j]));
      end
    end
  end

  a_unique_id: assert property (@(posedge clk) disable iff (!rst_n) !dup_id_s);

  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (result_valid && !result_ready) |=> (result_valid && $stable(result)));

  a_no_recommit: assert property (@(posedge clk) disable iff (!rst_n) !recommit_s);

endmodule

// File: rtl/cv32e40p_xif_inflight_buf.sv
// In-order circular buffer of accepted coprocessor instructions with
// commit-by-id lookup; the head entry feeds the execute stage.
module cv32e40p_xif_inflight_buf
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  xif_entry_t                           push_entry_i,
  input  logic                                 pop_i,
  input  logic                                 commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]                commit_id_i,
  input  logic                                 commit_kill_i,
  output logic                                 full_o,
  output logic                                 head_valid_o,
  output logic                                 head_committed_o,
  output logic                                 head_killed_o,
  output xif_entry_t                           head_entry_o,
  output logic                                 next_ready_o,
  output logic [DEPTH-1:0]                     ent_valid_o,
  output logic [DEPTH-1:0]                     ent_committed_o,
  output logic [DEPTH-1:0][X_ID_WIDTH-1:0]     ent_id_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  xif_entry_t        entries_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  committed_r;
  logic [DEPTH-1:0]  killed_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       count_r;
  logic [PW-1:0]     next_ptr_s;
  logic              push_commit_s;

  // A commit arriving with its own issue handshake lands on the entry being pushed
  assign push_commit_s = commit_valid_i && (commit_id_i == push_entry_i.id);

  // Entry storage, per-entry commit CAM update, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      valid_r     <= '0;
      committed_r <= '0;
      killed_r    <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && valid_r[i] && !committed_r[i] &&
            (entries_r[i].id == commit_id_i)) begin
          committed_r[i] <= 1'b1;
          killed_r[i]    <= commit_kill_i;
        end
      end
      if (pop_i) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
      end
      if (push_i) begin
        entries_r[wr_ptr_r]   <= push_entry_i;
        valid_r[wr_ptr_r]     <= 1'b1;
        committed_r[wr_ptr_r] <= push_commit_s;
        killed_r[wr_ptr_r]    <= push_commit_s && commit_kill_i;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign next_ptr_s       = rd_ptr_r + PTR_ONE;
  assign full_o           = (count_r == CNT_FULL);
  assign head_valid_o     = valid_r[rd_ptr_r];
  assign head_committed_o = committed_r[rd_ptr_r];
  assign head_killed_o    = killed_r[rd_ptr_r];
  assign head_entry_o     = entries_r[rd_ptr_r];
  assign next_ready_o     = valid_r[next_ptr_s] && committed_r[next_ptr_s] &&
                            !killed_r[next_ptr_s];
  assign ent_valid_o      = valid_r;
  assign ent_committed_o  = committed_r;

  // Flatten stored ids for the protocol checker
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_id_o[i] = entries_r[i].id;
    end
  end

endmodule

// File: rtl/cv32e40p_xif_coproc_responder.sv
// Reference XIF coprocessor: decodes custom-0 ADD3/MAXU/POPC, buffers accepted
// instructions in order and returns results once the core commits them.
module cv32e40p_xif_coproc_responder
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  parameter logic [6:0]  OPCODE  = 7'h0B
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_issue_valid_i,
  output logic          x_issue_ready_o,
  input  x_issue_req_t  x_issue_req_i,
  output x_issue_resp_t x_issue_resp_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_r;
  logic [CW-1:0]  cnt_r;
  logic           result_valid_r;
  x_result_t      result_r;

  logic           dec_s;
  logic           rs_ok_s;
  xif_op_e        op_s;
  logic           push_s;
  logic           pop_s;
  xif_entry_t     push_entry_s;
  logic           full_s;
  logic           head_valid_s;
  logic           head_committed_s;
  logic           head_killed_s;
  logic           next_ready_s;
  xif_entry_t     head_entry_s;
  logic           head_ready_s;
  logic [DEPTH-1:0]                 ent_valid_s;
  logic [DEPTH-1:0]                 ent_committed_s;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0] ent_id_s;
  logic           unused_s;

  function automatic logic [31:0] exec_op(input xif_entry_t e);
    logic [31:0] r;
    case (e.op)
      OP_ADD3: r = e.opa + e.opb + e.opc;
      OP_MAXU: r = (e.opa > e.opb) ? e.opa : e.opb;
      OP_POPC: r = {26'd0, popcount32(e.opa)};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Decode the offered instruction and check its source operands are present
  always_comb begin
    dec_s   = 1'b0;
    rs_ok_s = 1'b0;
    op_s    = OP_ADD3;
    if (x_issue_req_i.instr[6:0] == OPCODE) begin
      case (x_issue_req_i.instr[14:12])
        F3_ADD3: begin
          dec_s   = 1'b1;
          op_s    = OP_ADD3;
          rs_ok_s = &x_issue_req_i.rs_valid;
        end
        F3_MAXU: begin
          dec_s   = 1'b1;
          op_s    = OP_MAXU;
          rs_ok_s = (x_issue_req_i.rs_valid[1:0] == 2'b11);
        end
        F3_POPC: begin
          dec_s   = 1'b1;
          op_s    = OP_POPC;
          rs_ok_s = x_issue_req_i.rs_valid[0];
        end
        default: begin
          dec_s   = 1'b0;
          op_s    = OP_ADD3;
          rs_ok_s = 1'b0;
        end
      endcase
    end else begin
      dec_s = 1'b0;
    end
  end

  // Rejects always pass; only decodable instructions can stall
  assign x_issue_ready_o = dec_s ? (!full_s && rs_ok_s) : 1'b1;
  assign push_s          = x_issue_valid_i && dec_s && x_issue_ready_o;

  // Issue response: only accept/writeback are ever asserted
  always_comb begin
    x_issue_resp_o           = '0;
    x_issue_resp_o.accept    = x_issue_valid_i && dec_s;
    x_issue_resp_o.writeback = x_issue_valid_i && dec_s;
  end

  assign push_entry_s = '{id:  x_issue_req_i.id,
                          rd:  x_issue_req_i.instr[11:7],
                          op:  op_s,
                          opa: x_issue_req_i.rs[0],
                          opb: x_issue_req_i.rs[1],
                          opc: x_issue_req_i.rs[2]};

  assign unused_s = ^{x_issue_req_i.mode, x_issue_req_i.instr[31:15]};

  cv32e40p_xif_inflight_buf #(.DEPTH(DEPTH)) u_buf (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (push_s),
    .push_entry_i     (push_entry_s),
    .pop_i            (pop_s),
    .commit_valid_i   (x_commit_valid_i),
    .commit_id_i      (x_commit_i.id),
    .commit_kill_i    (x_commit_i.commit_kill),
    .full_o           (full_s),
    .head_valid_o     (head_valid_s),
    .head_committed_o (head_committed_s),
    .head_killed_o    (head_killed_s),
    .head_entry_o     (head_entry_s),
    .next_ready_o     (next_ready_s),
    .ent_valid_o      (ent_valid_s),
    .ent_committed_o  (ent_committed_s),
    .ent_id_o         (ent_id_s)
  );

  assign head_ready_s = head_valid_s && head_committed_s && !head_killed_s;

  // Pop a killed head while idle, or the reported head once the core takes the result
  always_comb begin
    case (state_r)
      S_IDLE:  pop_s = head_valid_s && head_killed_s;
      S_RESP:  pop_s = x_result_ready_i;
      default: pop_s = 1'b0;
    endcase
  end

  // Execute FSM with registered result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      cnt_r          <= '0;
      result_valid_r <= 1'b0;
      result_r       <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (head_ready_s) begin
            state_r <= S_EXEC;
            cnt_r   <= CNT_INIT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (cnt_r == '0) begin
            state_r          <= S_RESP;
            result_valid_r   <= 1'b1;
            result_r         <= '0;
            result_r.id      <= head_entry_s.id;
            result_r.data    <= exec_op(head_entry_s);
            result_r.rd      <= head_entry_s.rd;
            result_r.we      <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_RESP: begin
          if (x_result_ready_i) begin
            result_valid_r <= 1'b0;
            if (next_ready_s) begin
              state_r <= S_EXEC;
              cnt_r   <= CNT_INIT;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: begin
          state_r        <= S_IDLE;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign x_result_valid_o = result_valid_r;
  assign x_result_o       = result_r;

  cv32e40p_xif_coproc_responder_chk #(.DEPTH(DEPTH)) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .ent_valid     (ent_valid_s),
    .ent_committed (ent_committed_s),
    .ent_id        (ent_id_s),
    .commit_valid  (x_commit_valid_i),
    .commit_id     (x_commit_i.id),
    .result_valid  (x_result_valid_o),
    .result_ready  (x_result_ready_i),
    .result        (x_result_o)
  );

endmodule

// File: tb/tb_cv32e40p_xif_coproc_responder.sv
// Directed bench for the XIF reference coprocessor: issue, commit, kill,
// full buffer, operand stalls, back-to-back results and mid-flight reset.
module tb_cv32e40p_xif_coproc_responder;
  import cv32e40p_core_v_xif_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LATENCY = 2;

  logic          clk;
  logic          rst_n;
  logic          x_issue_valid_i;
  logic          x_issue_ready_o;
  x_issue_req_t  x_issue_req_i;
  x_issue_resp_t x_issue_resp_o;
  logic          x_commit_valid_i;
  x_commit_t     x_commit_i;
  logic          x_result_valid_o;
  logic          x_result_ready_i;
  x_result_t     x_result_o;

  int total;
  int bad;

  cv32e40p_xif_coproc_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .OPCODE(7'h0B)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .x_issue_valid_i  (x_issue_valid_i),
    .x_issue_ready_o  (x_issue_ready_o),
    .x_issue_req_i    (x_issue_req_i),
    .x_issue_resp_o   (x_issue_resp_o),
    .x_commit_valid_i (x_commit_valid_i),
    .x_commit_i       (x_commit_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_o       (x_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
    return {17'd0, f3, rd, opc};
  endfunction

  task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [2:0] rsv);
    x_issue_valid_i          = 1'b1;
    x_issue_req_i.instr      = instr;
    x_issue_req_i.mode       = 2'b11;
    x_issue_req_i.id         = id;
    x_issue_req_i.rs[0]      = a;
    x_issue_req_i.rs[1]      = b;
    x_issue_req_i.rs[2]      = c;
    x_issue_req_i.rs_valid   = rsv;
  endtask

  task automatic idle_issue();
    x_issue_valid_i = 1'b0;
    x_issue_req_i   = '0;
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    x_commit_valid_i       = 1'b1;
    x_commit_i.id          = id;
    x_commit_i.commit_kill = kill;
  endtask

  task automatic idle_commit();
    x_commit_valid_i = 1'b0;
    x_commit_i       = '0;
  endtask

  // Call at a negedge; cyc counts clock edges until result_valid is seen
  task automatic wait_valid(input int bound, output int cyc, output logic ok);
    cyc = 0;
    #1;
    while (x_result_valid_o !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    ok = (x_result_valid_o === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_issue();
    idle_commit();
    x_result_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (x_result_valid_o !== 1'b0 || x_result_o !== '0 || x_issue_resp_o !== '0 ||
        x_issue_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset valid=%b result=%h resp=%b ready=%b want 0 0 0 1",
               x_result_valid_o, x_result_o, x_issue_resp_o, x_issue_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add3();
    int cyc;
    logic ok;
    @(negedge clk);
    drive_issue(mk_instr(F3_ADD3, 5'd5, 7'h0B), 4'd3, 32'd1, 32'd2, 32'd3, 3'b111);
    #1;
    total++;
    if ({x_issue_ready_o, x_issue_resp_o.accept, x_issue_resp_o.writeback} !== 3'b111) begin
      bad++;
      $display("FAIL add3_issue ready/accept/wb=%b%b%b want 111",
               x_issue_ready_o, x_issue_resp_o.accept, x_issue_resp_o.writeback);
    end
    @(negedge clk);
    idle_issue();
    drive_commit(4'd3, 1'b0);
    @(negedge clk);
    idle_commit();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || cyc < LATENCY || cyc > LATENCY + 1) begin
      bad++;
      $display("FAIL add3_latency ok=%b cycles=%0d want %0d..%0d", ok, cyc, LATENCY, LATENCY + 1);
    end
    total++;
    if (x_result_o.id !== 4'd3 || x_result_o.data !== 32'd6) begin
      bad++;
      $display("FAIL add3_data id=%0d data=%h want id=3 data=6", x_result_o.id, x_result_o.data);
    end
    total++;
    if (x_result_o.rd !== 5'd5 || x_result_o.we !== 1'b1 || x_result_o.float !== 1'b0 ||
        x_result_o.exc !== 1'b0 || x_result_o.exccode !== 6'd0) begin
      bad++;
      $display("FAIL add3_fields rd=%0d we=%b float=%b exc=%b code=%0d want 5 1 0 0 0",
               x_result_o.rd, x_result_o.we, x_result_o.float, x_result_o.exc, x_result_o.exccode);
    end
    @(negedge clk);
    #1;
    total++;
    if (x_result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL add3_pop valid=%b want 0", x_result_valid_o);
    end
  endtask

  task automatic test_reject();
    logic seen;
    @(negedge clk);
    drive_issue(mk_instr(3'b000, 5'd6, 7'h33), 4'd9, 32'd7, 32'd8, 32'd9, 3'b111);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b1 || x_issue_resp_o.accept !== 1'b0 ||
        x_issue_resp_o.writeback !== 1'b0) begin
      bad++;
      $display("FAIL reject_issue ready=%b accept=%b wb=%b want 1 0 0",
               x_issue_ready_o, x_issue_resp_o.accept, x_issue_resp_o.writeback);
    end
    @(negedge clk);
    idle_issue();
    drive_commit(4'd9, 1'b0);
    @(negedge clk);
    idle_commit();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      seen = seen | (x_result_valid_o !== 1'b0);
    end
    total++;
    if (seen || dut.u_buf.count_r !== 3'd0) begin
      bad++;
      $display("FAIL reject_noresult result_seen=%b count=%0d want 0 0", seen, dut.u_buf.count_r);
    end
  endtask

  task automatic test_kill();
    logic seen;
    @(negedge clk);
    drive_issue(mk_instr(F3_MAXU, 5'd2, 7'h0B), 4'd1, 32'd5, 32'hFFFF_FFFF, 32'd0, 3'b011);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b1 || x_issue_resp_o.accept !== 1'b1) begin
      bad++;
      $display("FAIL kill_issue ready=%b accept=%b want 1 1", x_issue_ready_o, x_issue_resp_o.accept);
    end
    @(negedge clk);
    idle_issue();
    drive_commit(4'd1, 1'b1);
    @(negedge clk);
    idle_commit();
    @(negedge clk);
    #1;
    total++;
    if (dut.u_buf.count_r !== 3'd0) begin
      bad++;
      $display("FAIL kill_empty count=%0d want 0", dut.u_buf.count_r);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      seen = seen | (x_result_valid_o !== 1'b0);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL kill_noresult result_seen=%b want 0", seen);
    end
  endtask

  task automatic test_full();
    logic [31:0] src [4];
    logic [31:0] exp_d [4];
    x_result_t   cap;
    logic        stable;
    logic        ok;
    int          cyc;
    src   = '{32'h0000_0000, 32'h0000_0001, 32'h0000_00FF, 32'hFFFF_FFFF};
    exp_d = '{32'd0, 32'd1, 32'd8, 32'd32};
    x_result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_issue(mk_instr(F3_POPC, 5'(k + 1), 7'h0B), 4'(k + 4), src[k], 32'd0, 32'd0, 3'b001);
      #1;
      total++;
      if (x_issue_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL full_fill%0d ready=%b want 1", k, x_issue_ready_o);
      end
    end
    @(negedge clk);
    drive_issue(mk_instr(F3_POPC, 5'd9, 7'h0B), 4'd13, 32'd3, 32'd0, 32'd0, 3'b001);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_stall ready=%b want 0", x_issue_ready_o);
    end
    drive_issue(mk_instr(3'b000, 5'd9, 7'h33), 4'd14, 32'd3, 32'd0, 32'd0, 3'b111);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b1 || x_issue_resp_o.accept !== 1'b0) begin
      bad++;
      $display("FAIL full_reject ready=%b accept=%b want 1 0", x_issue_ready_o, x_issue_resp_o.accept);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_issue();
      drive_commit(4'(k + 4), 1'b0);
    end
    @(negedge clk);
    idle_commit();
    wait_valid(20, cyc, ok);
    cap = x_result_o;
    stable = ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      stable = stable && (x_result_valid_o === 1'b1) && (x_result_o === cap);
    end
    total++;
    if (!stable || cap.id !== 4'd4 || cap.data !== 32'd0) begin
      bad++;
      $display("FAIL full_hold stable=%b id=%0d data=%h want 1 4 0", stable, cap.id, cap.data);
    end
    x_result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(20, cyc, ok);
      total++;
      if (!ok || x_result_o.id !== 4'(k + 4) || x_result_o.data !== exp_d[k] ||
          x_result_o.rd !== 5'(k + 1)) begin
        bad++;
        $display("FAIL full_result%0d ok=%b id=%0d data=%0d rd=%0d want id=%0d data=%0d rd=%0d",
                 k, ok, x_result_o.id, x_result_o.data, x_result_o.rd, k + 4, exp_d[k], k + 1);
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (x_result_valid_o !== 1'b0 || dut.u_buf.count_r !== 3'd0) begin
      bad++;
      $display("FAIL full_drain valid=%b count=%0d want 0 0", x_result_valid_o, dut.u_buf.count_r);
    end
  endtask

  task automatic test_rs_wait();
    int cyc;
    logic ok;
    @(negedge clk);
    drive_issue(mk_instr(F3_ADD3, 5'd3, 7'h0B), 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 3'b011);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rs_wait0 ready=%b want 0", x_issue_ready_o);
    end
    @(negedge clk);
    #1;
    total++;
    if (x_issue_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rs_wait1 ready=%b want 0", x_issue_ready_o);
    end
    x_issue_req_i.rs_valid = 3'b111;
    #1;
    total++;
    if (x_issue_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rs_go ready=%b want 1", x_issue_ready_o);
    end
    @(negedge clk);
    idle_issue();
    drive_commit(4'd2, 1'b0);
    @(negedge clk);
    idle_commit();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || x_result_o.id !== 4'd2 || x_result_o.data !== 32'd1) begin
      bad++;
      $display("FAIL add3_wrap ok=%b id=%0d data=%h want 2 1", ok, x_result_o.id, x_result_o.data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic ok;
    @(negedge clk);
    drive_issue(mk_instr(F3_MAXU, 5'd7, 7'h0B), 4'd8, 32'd5, 32'hFFFF_FFFF, 32'd0, 3'b011);
    drive_commit(4'd8, 1'b0);
    @(negedge clk);
    drive_issue(mk_instr(F3_ADD3, 5'd9, 7'h0B), 4'd10, 32'd10, 32'd20, 32'd30, 3'b111);
    drive_commit(4'd10, 1'b0);
    @(negedge clk);
    idle_issue();
    idle_commit();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || x_result_o.id !== 4'd8 || x_result_o.data !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL b2b_maxu ok=%b id=%0d data=%h want 8 ffffffff", ok, x_result_o.id, x_result_o.data);
    end
    @(negedge clk);
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || cyc != LATENCY || x_result_o.id !== 4'd10 || x_result_o.data !== 32'd60) begin
      bad++;
      $display("FAIL b2b_add3 ok=%b gap=%0d id=%0d data=%0d want gap=%0d id=10 data=60",
               ok, cyc, x_result_o.id, x_result_o.data, LATENCY);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic ok;
    x_result_ready_i = 1'b0;
    @(negedge clk);
    drive_issue(mk_instr(F3_POPC, 5'd4, 7'h0B), 4'd11, 32'h0000_000F, 32'd0, 32'd0, 3'b001);
    drive_commit(4'd11, 1'b0);
    @(negedge clk);
    idle_issue();
    idle_commit();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || x_result_o.data !== 32'd4) begin
      bad++;
      $display("FAIL rstmid_resp ok=%b data=%0d want 1 4", ok, x_result_o.data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (x_result_valid_o !== 1'b0 || x_result_o !== '0) begin
      bad++;
      $display("FAIL rstmid_drop valid=%b result=%h want 0 0", x_result_valid_o, x_result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x_result_ready_i = 1'b1;
    #1;
    total++;
    if (dut.u_buf.count_r !== 3'd0 || x_result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_empty count=%0d valid=%b want 0 0", dut.u_buf.count_r, x_result_valid_o);
    end
    @(negedge clk);
    drive_issue(mk_instr(F3_ADD3, 5'd4, 7'h0B), 4'd12, 32'd1, 32'd1, 32'd1, 3'b111);
    drive_commit(4'd12, 1'b0);
    @(negedge clk);
    idle_issue();
    idle_commit();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || x_result_o.id !== 4'd12 || x_result_o.data !== 32'd3) begin
      bad++;
      $display("FAIL rstmid_after ok=%b id=%0d data=%0d want 12 3", ok, x_result_o.id, x_result_o.data);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add3();
    test_reject();
    test_kill();
    test_full();
    test_rs_wait();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
